// File: rtl/dffn_async_bist_driver_if.sv
// Bus between the negative-edge flop self-test driver and its harness.
// The driver takes the slave view (it consumes START and the flop's Q and
// produces the flop stimulus plus status); the harness takes the master view.
interface dffn_async_bist_driver_if;
    logic       START;
    logic       DUT_Q;
    logic       DUT_CLKN;
    logic       DUT_D;
    logic       DUT_RN;
    logic       DUT_SETN;
    logic       BUSY;
    logic       DONE;
    logic       PASS;
    logic [7:0] ERR_CNT;
    logic [3:0] FAIL_STEP;

    modport master (
        output START, DUT_Q,
        input  DUT_CLKN, DUT_D, DUT_RN, DUT_SETN, BUSY, DONE, PASS, ERR_CNT, FAIL_STEP
    );

    modport slave (
        input  START, DUT_Q,
        output DUT_CLKN, DUT_D, DUT_RN, DUT_SETN, BUSY, DONE, PASS, ERR_CNT, FAIL_STEP
    );
endinterface

// File: rtl/dffn_async_bist_driver.sv
// Self-test driver/checker for a negative-edge D flop with active-low async
// reset and set. Each loop walks six steps of four phases: P0 drives the
// step's D/RN/SETN, P1/P2 produce an optional falling then rising DUT_CLKN,
// P3 samples DUT_Q. The sampled value is scored on the following edge.
// The phase counter leads the registered DUT_* outputs by one cycle, so the
// P3 sample is taken one full cycle after the last stimulus change.
module dffn_async_bist_driver #(
    parameter int unsigned LOOPS = 4
) (
    input  logic                      CLK,
    input  logic                      RN,
    dffn_async_bist_driver_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    typedef struct packed {
        logic d;
        logic rn;
        logic setn;
        logic clocked;
        logic exp;
    } step_t;

    localparam logic [7:0] LAST_LOOP = 8'(LOOPS - 1);
    localparam logic [2:0] LAST_STEP = 3'd5;
    localparam logic [3:0] NO_FAIL   = 4'hF;

    // Stimulus and expected Q for step s; dsel is bit 0 of the loop index,
    // which alternates the data polarity of the two clocked-data steps.
    function automatic step_t step_vec(input logic [2:0] s, input logic dsel);
        step_t v;
        v      = '0;
        v.rn   = 1'b1;
        v.setn = 1'b1;
        case (s)
            3'd0: v.rn = 1'b0;
            3'd1: begin
                v.d       = ~dsel;
                v.clocked = 1'b1;
                v.exp     = ~dsel;
            end
            3'd2: begin
                v.d       = dsel;
                v.clocked = 1'b1;
                v.exp     = dsel;
            end
            3'd3: begin
                v.setn = 1'b0;
                v.exp  = 1'b1;
            end
            3'd4: v.clocked = 1'b1;
            3'd5: v.d = 1'b1;
            default: v = v;
        endcase
        return v;
    endfunction

    // Error counter increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t     state_q,     state_d;
    logic [7:0] loop_q,      loop_d;
    logic [2:0] step_q,      step_d;
    logic [1:0] phase_q,     phase_d;
    logic       drain_q,     drain_d;
    logic       cmp_vld_q,   cmp_vld_d;
    logic       q_smp_q,     q_smp_d;
    logic       exp_q,       exp_d;
    logic [2:0] cmp_step_q,  cmp_step_d;
    logic       dut_clkn_q,  dut_clkn_d;
    logic       dut_d_q,     dut_d_d;
    logic       dut_rn_q,    dut_rn_d;
    logic       dut_setn_q,  dut_setn_d;
    logic       busy_q,      busy_d;
    logic       done_q,      done_d;
    logic       pass_q,      pass_d;
    logic [7:0] err_cnt_q,   err_cnt_d;
    logic [3:0] fail_step_q, fail_step_d;

    step_t      cur;
    logic [7:0] err_next;
    logic [3:0] fail_next;

    // Next-state, sequencing, stimulus and scoring for the whole driver.
    always_comb begin
        state_d     = state_q;
        loop_d      = loop_q;
        step_d      = step_q;
        phase_d     = phase_q;
        drain_d     = drain_q;
        cmp_vld_d   = 1'b0;
        q_smp_d     = q_smp_q;
        exp_d       = exp_q;
        cmp_step_d  = cmp_step_q;
        dut_clkn_d  = dut_clkn_q;
        dut_d_d     = dut_d_q;
        dut_rn_d    = dut_rn_q;
        dut_setn_d  = dut_setn_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;

        cur = step_vec(step_q, loop_q[0]);

        // Score the sample taken on the previous edge.
        err_next  = err_cnt_q;
        fail_next = fail_step_q;
        if (cmp_vld_q && (q_smp_q != exp_q)) begin
            err_next = sat_inc(err_cnt_q);
            if (fail_step_q == NO_FAIL) begin
                fail_next = {1'b0, cmp_step_q};
            end
        end
        err_cnt_d   = err_next;
        fail_step_d = fail_next;

        case (state_q)
            ST_IDLE, ST_FIN: begin
                dut_clkn_d = 1'b1;
                dut_d_d    = 1'b0;
                dut_rn_d   = 1'b1;
                dut_setn_d = 1'b1;
                busy_d     = 1'b0;
                if (bus.START) begin
                    state_d     = ST_RUN;
                    loop_d      = 8'd0;
                    step_d      = 3'd0;
                    phase_d     = 2'd0;
                    drain_d     = 1'b0;
                    err_cnt_d   = 8'd0;
                    fail_step_d = NO_FAIL;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                end
            end
            ST_RUN: begin
                busy_d = 1'b1;
                if (drain_q) begin
                    // Final sample is scored on this edge; publish the result.
                    state_d    = ST_FIN;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    pass_d     = (err_next == 8'd0);
                    dut_clkn_d = 1'b1;
                    dut_d_d    = 1'b0;
                    dut_rn_d   = 1'b1;
                    dut_setn_d = 1'b1;
                end else begin
                    case (phase_q)
                        2'd0: begin
                            dut_d_d    = cur.d;
                            dut_rn_d   = cur.rn;
                            dut_setn_d = cur.setn;
                        end
                        2'd1: dut_clkn_d = ~cur.clocked;
                        2'd2: dut_clkn_d = 1'b1;
                        default: begin
                            cmp_vld_d  = 1'b1;
                            q_smp_d    = bus.DUT_Q;
                            exp_d      = cur.exp;
                            cmp_step_d = step_q;
                        end
                    endcase

                    if (phase_q == 2'd3) begin
                        phase_d = 2'd0;
                        if (step_q == LAST_STEP) begin
                            step_d = 3'd0;
                            if (loop_q == LAST_LOOP) begin
                                drain_d = 1'b1;
                            end else begin
                                loop_d = loop_q + 8'd1;
                            end
                        end else begin
                            step_d = step_q + 3'd1;
                        end
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; RN low abandons any run and parks the flop in reset.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q     <= ST_IDLE;
            loop_q      <= 8'd0;
            step_q      <= 3'd0;
            phase_q     <= 2'd0;
            drain_q     <= 1'b0;
            cmp_vld_q   <= 1'b0;
            q_smp_q     <= 1'b0;
            exp_q       <= 1'b0;
            cmp_step_q  <= 3'd0;
            dut_clkn_q  <= 1'b1;
            dut_d_q     <= 1'b0;
            dut_rn_q    <= 1'b0;
            dut_setn_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= 8'd0;
            fail_step_q <= NO_FAIL;
        end else begin
            state_q     <= state_d;
            loop_q      <= loop_d;
            step_q      <= step_d;
            phase_q     <= phase_d;
            drain_q     <= drain_d;
            cmp_vld_q   <= cmp_vld_d;
            q_smp_q     <= q_smp_d;
            exp_q       <= exp_d;
            cmp_step_q  <= cmp_step_d;
            dut_clkn_q  <= dut_clkn_d;
            dut_d_q     <= dut_d_d;
            dut_rn_q    <= dut_rn_d;
            dut_setn_q  <= dut_setn_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_cnt_q   <= err_cnt_d;
            fail_step_q <= fail_step_d;
        end
    end

    assign bus.DUT_CLKN  = dut_clkn_q;
    assign bus.DUT_D     = dut_d_q;
    assign bus.DUT_RN    = dut_rn_q;
    assign bus.DUT_SETN  = dut_setn_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.PASS      = pass_q;
    assign bus.ERR_CNT   = err_cnt_q;
    assign bus.FAIL_STEP = fail_step_q;

endmodule

// File: tb/tb_dffn_async_bist_driver.sv
// Bench for dffn_async_bist_driver: four drivers (LOOPS = 4, 1, 2, 255), each
// beside a behavioural flop model whose fault mode is selectable
// (0 ideal, 1 Q stuck 0, 2 Q stuck 1, 3 ignores SETN, 4 transparent latch).
module tb_dffn_async_bist_driver;

    logic clk = 1'b0;
    logic rn;
    always #5 clk = ~clk;

    logic       start_a [4];
    int         mode_a  [4];
    logic       clkn_a  [4];
    logic       d_a     [4];
    logic       rn_a    [4];
    logic       setn_a  [4];
    logic       busy_a  [4];
    logic       done_a  [4];
    logic       pass_a  [4];
    logic [7:0] err_a   [4];
    logic [3:0] fail_a  [4];

    int n_cmp = 0;
    int n_bad = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int LP = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : 255;

        dffn_async_bist_driver_if bus ();

        dffn_async_bist_driver #(.LOOPS(LP)) u_dut (
            .CLK (clk),
            .RN  (rn),
            .bus (bus)
        );

        logic ff_q      = 1'b0;
        logic prev_clkn = 1'b1;
        logic latch_q;

        always @(bus.DUT_CLKN or bus.DUT_RN or bus.DUT_SETN) begin
            if (bus.DUT_RN === 1'b0) ff_q = 1'b0;
            else if (bus.DUT_SETN === 1'b0 && mode_a[g] != 3) ff_q = 1'b1;
            else if (prev_clkn === 1'b1 && bus.DUT_CLKN === 1'b0) ff_q = bus.DUT_D;
            prev_clkn = bus.DUT_CLKN;
        end

        always_comb begin
            latch_q = 1'b0;
            if (bus.DUT_RN === 1'b0) latch_q = 1'b0;
            else if (bus.DUT_SETN === 1'b0) latch_q = 1'b1;
            else latch_q = bus.DUT_D;
        end

        assign bus.START = start_a[g];
        assign bus.DUT_Q = (mode_a[g] == 1) ? 1'b0 :
                           (mode_a[g] == 2) ? 1'b1 :
                           (mode_a[g] == 4) ? latch_q : ff_q;

        assign clkn_a[g] = bus.DUT_CLKN;
        assign d_a[g]    = bus.DUT_D;
        assign rn_a[g]   = bus.DUT_RN;
        assign setn_a[g] = bus.DUT_SETN;
        assign busy_a[g] = bus.BUSY;
        assign done_a[g] = bus.DONE;
        assign pass_a[g] = bus.PASS;
        assign err_a[g]  = bus.ERR_CNT;
        assign fail_a[g] = bus.FAIL_STEP;
    end

    function automatic int loops_of(input int idx);
        case (idx)
            0: return 4;
            1: return 1;
            2: return 2;
            default: return 255;
        endcase
    endfunction

    // Step-level reference: walks the step table, applies each step to an
    // abstract flop of the chosen fault mode, and scores Q against expectation.
    task automatic ref_model(input int loops, input int mode,
                             output int err, output int fstep, output int falls);
        // D/expected selectors: 0 zero, 1 one, 2 d, 3 ~d
        int dsel [6] = '{0, 3, 2, 0, 0, 1};
        int esel [6] = '{0, 3, 2, 1, 0, 0};
        int rnv  [6] = '{0, 1, 1, 1, 1, 1};
        int snv  [6] = '{1, 1, 1, 0, 1, 1};
        int ckv  [6] = '{0, 1, 1, 0, 1, 0};
        int q, d, dv, ev;
        err = 0; fstep = 15; falls = 0; q = 0;
        for (int l = 0; l < loops; l++) begin
            d = l % 2;
            for (int s = 0; s < 6; s++) begin
                dv = (dsel[s] == 0) ? 0 : (dsel[s] == 1) ? 1 : (dsel[s] == 2) ? d : 1 - d;
                ev = (esel[s] == 0) ? 0 : (esel[s] == 1) ? 1 : (esel[s] == 2) ? d : 1 - d;
                case (mode)
                    1: q = 0;
                    2: q = 1;
                    3: begin
                        if (rnv[s] == 0) q = 0;
                        else if (ckv[s] == 1) q = dv;
                    end
                    4: q = (rnv[s] == 0) ? 0 : (snv[s] == 0) ? 1 : dv;
                    default: begin
                        if (rnv[s] == 0) q = 0;
                        else if (snv[s] == 0) q = 1;
                        else if (ckv[s] == 1) q = dv;
                    end
                endcase
                falls += ckv[s];
                if (q != ev) begin
                    if (err < 255) err++;
                    if (fstep == 15) fstep = s;
                end
            end
        end
    endtask

    task automatic run_check(input int idx, input int mode, input string tag);
        int loops, e_err, e_fail, e_falls, cyc, falls, limit;
        logic prev, got_done;
        loops = loops_of(idx);
        ref_model(loops, mode, e_err, e_fail, e_falls);
        mode_a[idx] = mode;
        limit = 24 * loops + 20;

        @(negedge clk);
        start_a[idx] = 1'b1;
        @(posedge clk);
        #1 start_a[idx] = 1'b0;

        n_cmp++;
        if ({busy_a[idx], done_a[idx], err_a[idx], fail_a[idx]} !== {1'b0, 1'b0, 8'h00, 4'hF}) begin
            n_bad++;
            $display("FAIL %s start_clear: busy/done/err/fail=%b/%b/%0d/%h required 0/0/0/f",
                     tag, busy_a[idx], done_a[idx], err_a[idx], fail_a[idx]);
        end

        cyc = 0; falls = 0; got_done = 1'b0; prev = clkn_a[idx];
        while (!got_done && cyc < limit) begin
            if (cyc == 5) start_a[idx] = 1'b1;
            if (cyc == 6) start_a[idx] = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
            if (prev === 1'b1 && clkn_a[idx] === 1'b0) falls++;
            prev = clkn_a[idx];
            if (cyc == 1) begin
                n_cmp++;
                if ({busy_a[idx], d_a[idx], rn_a[idx], setn_a[idx], clkn_a[idx]} !== 5'b1_0_0_1_1) begin
                    n_bad++;
                    $display("FAIL %s first_step: busy,d,rn,setn,clkn=%b%b%b%b%b required 10011",
                             tag, busy_a[idx], d_a[idx], rn_a[idx], setn_a[idx], clkn_a[idx]);
                end
            end
            if (done_a[idx] === 1'b1) got_done = 1'b1;
        end
        start_a[idx] = 1'b0;

        n_cmp++;
        if (!got_done) begin
            n_bad++;
            $display("FAIL %s done_timeout: no DONE within %0d cycles", tag, limit);
        end else begin
            if (cyc != 24 * loops + 1) begin
                n_bad++;
                $display("FAIL %s latency: DONE after %0d cycles required %0d", tag, cyc, 24 * loops + 1);
            end
            n_cmp++;
            if (busy_a[idx] !== 1'b0 || pass_a[idx] !== 1'(e_err == 0)) begin
                n_bad++;
                $display("FAIL %s busy_pass: busy=%b pass=%b required 0/%0d",
                         tag, busy_a[idx], pass_a[idx], e_err == 0);
            end
            n_cmp++;
            if (err_a[idx] !== 8'(e_err)) begin
                n_bad++;
                $display("FAIL %s err_cnt: got %0d required %0d", tag, err_a[idx], e_err);
            end
            n_cmp++;
            if (fail_a[idx] !== 4'(e_fail)) begin
                n_bad++;
                $display("FAIL %s fail_step: got %h required %h", tag, fail_a[idx], 4'(e_fail));
            end
            n_cmp++;
            if (falls != e_falls) begin
                n_bad++;
                $display("FAIL %s clkn_falls: got %0d required %0d", tag, falls, e_falls);
            end
            n_cmp++;
            if ({clkn_a[idx], d_a[idx], rn_a[idx], setn_a[idx]} !== 4'b1011) begin
                n_bad++;
                $display("FAIL %s idle_levels: clkn,d,rn,setn=%b%b%b%b required 1011",
                         tag, clkn_a[idx], d_a[idx], rn_a[idx], setn_a[idx]);
            end
        end
    endtask

    task automatic test_reset();
        logic [18:0] obs;
        rn = 1'b1;
        #3 rn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            obs = {clkn_a[i], d_a[i], rn_a[i], setn_a[i], busy_a[i], done_a[i], pass_a[i], err_a[i], fail_a[i]};
            n_cmp++;
            if (obs !== {1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 8'h00, 4'hF}) begin
                n_bad++;
                $display("FAIL reset_values[%0d]: got %b required %b", i, obs,
                         {1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 8'h00, 4'hF});
            end
        end
        @(negedge clk) rn = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({clkn_a[0], d_a[0], rn_a[0], setn_a[0], busy_a[0]} !== 5'b1_0_1_1_0) begin
            n_bad++;
            $display("FAIL reset_release_idle: clkn,d,rn,setn,busy=%b%b%b%b%b required 10110",
                     clkn_a[0], d_a[0], rn_a[0], setn_a[0], busy_a[0]);
        end
    endtask

    task automatic test_ideal();          run_check(0, 0, "ideal_l4");       endtask
    task automatic test_stuck0();         run_check(1, 1, "stuck0_l1");      endtask
    task automatic test_back_to_back();   run_check(1, 0, "restart_l1");     endtask
    task automatic test_ignore_setn();    run_check(2, 3, "nosetn_l2");      endtask
    task automatic test_latch();          run_check(1, 4, "latch_l1");       endtask
    task automatic test_saturate();       run_check(3, 2, "stuck1_l255");    endtask

    task automatic test_rn_midrun();
        logic [18:0] obs;
        mode_a[0] = 0;
        @(negedge clk);
        start_a[0] = 1'b1;
        @(posedge clk);
        #1 start_a[0] = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        n_cmp++;
        if (busy_a[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL midrun_busy: got %b required 1", busy_a[0]);
        end
        rn = 1'b0;
        #1;
        obs = {clkn_a[0], d_a[0], rn_a[0], setn_a[0], busy_a[0], done_a[0], pass_a[0], err_a[0], fail_a[0]};
        n_cmp++;
        if (obs !== {1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 8'h00, 4'hF}) begin
            n_bad++;
            $display("FAIL midrun_reset: got %b required %b", obs, {1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 8'h00, 4'hF});
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy_a[0], done_a[0], rn_a[0]} !== 3'b001) begin
            n_bad++;
            $display("FAIL midrun_abandoned: busy,done,rn=%b%b%b required 001", busy_a[0], done_a[0], rn_a[0]);
        end
        run_check(0, 0, "after_rn_l4");
    endtask

    task automatic test_random();
        int idx, mode;
        for (int i = 0; i < 8; i++) begin
            idx  = $urandom_range(0, 2);
            mode = $urandom_range(0, 4);
            repeat ($urandom_range(0, 4)) @(posedge clk);
            run_check(idx, mode, $sformatf("rand%0d_i%0d_m%0d", i, idx, mode));
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            start_a[i] = 1'b0;
            mode_a[i]  = 0;
        end
        test_reset();
        test_ideal();
        test_stuck0();
        test_back_to_back();
        test_ignore_setn();
        test_latch();
        test_rn_midrun();
        test_random();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
